// File: rtl/interrupt_sequencer_if.sv
// rtl/interrupt_sequencer_if.sv - fetch/hazard/decode signal bundle for the interrupt sequencer
interface interrupt_sequencer_if #(
    parameter int INSTR_W = 16
);
    logic               int_req;
    logic               fetch_valid;
    logic [2:0]         fetch_func;
    logic               branch_pending;
    logic               stall_in;
    logic               inj_valid;
    logic [INSTR_W-1:0] inj_instr;
    logic               pc_hold;
    logic               int_ack;
    logic               busy;

    modport slave (
        input  int_req, fetch_valid, fetch_func, branch_pending, stall_in,
        output inj_valid, inj_instr, pc_hold, int_ack, busy
    );

    modport master (
        output int_req, fetch_valid, fetch_func, branch_pending, stall_in,
        input  inj_valid, inj_instr, pc_hold, int_ack, busy
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - takes an external interrupt at a safe fetch boundary and injects NOPs plus the interrupt opcode
module interrupt_sequencer #(
    parameter int                 INSTR_W       = 16,
    parameter int                 BUBBLE_CYCLES = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR     = 16'h07F8,
    parameter logic [INSTR_W-1:0] INT_OP1       = 16'hF480,
    parameter logic [INSTR_W-1:0] INT_OP2       = 16'hF500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    interrupt_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_SAFE = 3'd1,
        S_SKIP_IMM  = 3'd2,
        S_BUBBLE    = 3'd3,
        S_INJ1      = 3'd4,
        S_INJ2      = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic       r_int_req_q;
    logic       r_pending;
    logic       w_req_edge;
    logic       w_leave_idle;
    logic       w_imm;
    logic       w_legal;

    assign w_req_edge = bus.int_req & ~r_int_req_q;
    assign w_imm      = bus.fetch_valid & (bus.fetch_func == 3'b100);
    assign w_legal    = (r_state <= S_INJ2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_int_req_q <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_int_req_q <= bus.int_req;
            // a fresh edge on the same clock as the clear keeps the request alive
            if (w_req_edge) begin
                r_pending <= 1'b1;
            end else if (w_leave_idle) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_leave_idle = 1'b0;
        if (!w_legal) begin
            w_state_nxt = S_IDLE;
        end else if (!bus.stall_in) begin
            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        w_leave_idle = 1'b1;
                        if (w_imm) begin
                            w_state_nxt = S_SKIP_IMM;
                        end else if (bus.branch_pending) begin
                            w_state_nxt = S_WAIT_SAFE;
                        end else begin
                            w_state_nxt = S_BUBBLE;
                            w_cnt_nxt   = 3'(BUBBLE_CYCLES);
                        end
                    end
                end
                S_WAIT_SAFE: begin
                    if (!bus.branch_pending) begin
                        if (w_imm) begin
                            w_state_nxt = S_SKIP_IMM;
                        end else begin
                            w_state_nxt = S_BUBBLE;
                            w_cnt_nxt   = 3'(BUBBLE_CYCLES);
                        end
                    end
                end
                S_SKIP_IMM: begin
                    w_state_nxt = S_BUBBLE;
                    w_cnt_nxt   = 3'(BUBBLE_CYCLES);
                end
                S_BUBBLE: begin
                    if (r_cnt == 3'd1) begin
                        w_state_nxt = S_INJ1;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                S_INJ1:  w_state_nxt = S_INJ2;
                S_INJ2:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy      = 1'b0;
        bus.pc_hold   = 1'b0;
        bus.inj_valid = 1'b0;
        bus.inj_instr = '0;
        bus.int_ack   = 1'b0;
        case (r_state)
            S_WAIT_SAFE, S_SKIP_IMM: begin
                bus.busy = 1'b1;
            end
            S_BUBBLE: begin
                bus.busy      = 1'b1;
                bus.pc_hold   = 1'b1;
                bus.inj_valid = 1'b1;
                bus.inj_instr = NOP_INSTR;
            end
            S_INJ1: begin
                bus.busy      = 1'b1;
                bus.pc_hold   = 1'b1;
                bus.inj_valid = 1'b1;
                bus.inj_instr = INT_OP1;
            end
            S_INJ2: begin
                bus.busy      = 1'b1;
                bus.pc_hold   = 1'b1;
                bus.inj_valid = 1'b1;
                bus.inj_instr = INT_OP2;
                bus.int_ack   = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end
endmodule
